// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/adjust controller; lap hold enabled by STOPWATCH_LAP_EN
module stopwatch_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       rstBtn,
  input  logic       pueBtn,
  input  logic       sel,
  input  logic       adj,
  input  logic       lap_btn,
  input  logic [5:0] seccounter,
  input  logic [5:0] mincounter,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       clr,
  output logic       running,
  output logic       blink_min,
  output logic       blink_sec,
  output logic       hold
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_saved_run;
  logic   w_saved_run_nxt;
  logic   r_rst_prev;
  logic   r_pue_prev;
  logic   w_rst_edge;
  logic   w_pue_edge;
  logic   w_inc_sec;
  logic   w_inc_min;
  logic   w_clr;
  logic   w_hold_nxt;
  logic   w_min_unused;

  // Minute wrap is handled entirely by the datapath.
  assign w_min_unused = |mincounter;

  assign w_rst_edge = rstBtn & ~r_rst_prev;
  assign w_pue_edge = pueBtn & ~r_pue_prev;

`ifdef STOPWATCH_LAP_EN
  logic r_lap_prev;
  logic w_lap_edge;
  assign w_lap_edge = lap_btn & ~r_lap_prev;
`else
  logic w_lap_unused;
  assign w_lap_unused = lap_btn;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_saved_run_nxt = r_saved_run;
    w_inc_sec       = 1'b0;
    w_inc_min       = 1'b0;
    w_clr           = 1'b0;
    w_hold_nxt      = hold;
    if (w_rst_edge) begin
      w_clr           = 1'b1;
      w_saved_run_nxt = 1'b1;
      w_state_nxt     = adj ? ST_ADJ : ST_RUN;
    end else begin
      if (r_state != ST_ADJ && adj) begin
        w_saved_run_nxt = (r_state == ST_RUN);
        w_state_nxt     = ST_ADJ;
      end else if (r_state == ST_ADJ && !adj) begin
        w_state_nxt = r_saved_run ? ST_RUN : ST_PAUSE;
      end
      if (w_pue_edge) begin
        if (w_state_nxt == ST_ADJ) begin
          w_saved_run_nxt = ~w_saved_run_nxt;
        end else begin
          w_state_nxt = (w_state_nxt == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
      end
      // Ticks are judged against the post-transition state and current sel.
      case (w_state_nxt)
        ST_RUN: begin
          if (tick_1hz) begin
            w_inc_sec = 1'b1;
            w_inc_min = (seccounter == 6'd59);
          end
        end
        ST_ADJ: begin
          if (tick_2hz) begin
            w_inc_sec = sel;
            w_inc_min = ~sel;
          end
        end
        default: ;
      endcase
    end
`ifdef STOPWATCH_LAP_EN
    if (w_lap_edge && w_state_nxt == ST_RUN) begin
      w_hold_nxt = ~hold;
    end
    if (w_clr || (w_state_nxt == ST_ADJ && r_state != ST_ADJ)) begin
      w_hold_nxt = 1'b0;
    end
`else
    w_hold_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_saved_run <= 1'b1;
      r_rst_prev  <= 1'b1;
      r_pue_prev  <= 1'b1;
      inc_sec     <= 1'b0;
      inc_min     <= 1'b0;
      clr         <= 1'b0;
      running     <= 1'b1;
      blink_min   <= 1'b0;
      blink_sec   <= 1'b0;
      hold        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_saved_run <= w_saved_run_nxt;
      r_rst_prev  <= rstBtn;
      r_pue_prev  <= pueBtn;
      inc_sec     <= w_inc_sec;
      inc_min     <= w_inc_min;
      clr         <= w_clr;
      running     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_ADJ && w_saved_run_nxt);
      blink_min   <= (w_state_nxt == ST_ADJ) && !sel;
      blink_sec   <= (w_state_nxt == ST_ADJ) && sel;
      hold        <= w_hold_nxt;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lap_prev <= 1'b1;
    end else begin
      r_lap_prev <= lap_btn;
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - bench for stopwatch_ctrl with a flag-based reference model
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick_1hz, tick_2hz, rstBtn, pueBtn, sel, adj, lap_btn;
  logic [5:0] seccounter, mincounter;
  logic       inc_sec, inc_min, clr, running, blink_min, blink_sec, hold;
  wire  [6:0] obs = {inc_sec, inc_min, clr, running, blink_min, blink_sec, hold};

  int checks = 0;
  int errs   = 0;

  // Model: run/pause is one "paused" flag that doubles as the resume target in adjust.
  bit       m_prev_r, m_prev_p, m_prev_l;
  bit       m_in_adj, m_paused, m_hold;
  bit [6:0] m_exp;

  stopwatch_ctrl dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .rstBtn(rstBtn), .pueBtn(pueBtn), .sel(sel), .adj(adj), .lap_btn(lap_btn),
    .seccounter(seccounter), .mincounter(mincounter),
    .inc_sec(inc_sec), .inc_min(inc_min), .clr(clr), .running(running),
    .blink_min(blink_min), .blink_sec(blink_sec), .hold(hold)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit pr, pp, pl, was_adj, s, m, c;
    if (rst) begin
      m_prev_r = 1; m_prev_p = 1; m_prev_l = 1;
      m_in_adj = 0; m_paused = 0; m_hold = 0;
      m_exp = 7'b0001000;
      return;
    end
    pr = rstBtn & !m_prev_r;
    pp = pueBtn & !m_prev_p;
    pl = lap_btn & !m_prev_l;
    was_adj = m_in_adj;
    s = 0; m = 0; c = 0;
    m_in_adj = adj;
    if (pr) begin
      c = 1;
      m_paused = 0;
    end else begin
      if (pp) m_paused = !m_paused;
      if (m_in_adj) begin
        if (tick_2hz) begin
          if (sel) s = 1; else m = 1;
        end
      end else if (!m_paused && tick_1hz) begin
        s = 1;
        m = (seccounter == 59);
      end
    end
    if (LAP && pl && !m_in_adj && !m_paused) m_hold = !m_hold;
    if (c || (m_in_adj && !was_adj)) m_hold = 0;
    m_prev_r = rstBtn; m_prev_p = pueBtn; m_prev_l = lap_btn;
    m_exp = {s, m, c, !m_paused, m_in_adj & !sel, m_in_adj & sel, m_hold};
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; rstBtn = 1; pueBtn = 1; lap_btn = 1; adj = 0; sel = 0;
    tick_1hz = 1; tick_2hz = 1; seccounter = 59; mincounter = 0;
    step(); step();
    checks++;
    if (obs !== 7'b0001000) begin
      $display("FAIL reset_state got=%b want=%b", obs, 7'b0001000); errs++;
    end
    rst = 0; tick_1hz = 0; tick_2hz = 0;
    step();
    checks++;
    if (obs !== 7'b0001000 || obs !== m_exp) begin
      $display("FAIL held_buttons_no_press got=%b want=%b", obs, 7'b0001000); errs++;
    end
    rstBtn = 0; pueBtn = 0; lap_btn = 0;
    step();
  endtask

  task automatic test_count();
    seccounter = 5;
    for (int i = 0; i < 10; i++) begin
      tick_1hz = 1; step(); tick_1hz = 0;
      checks++;
      if ({inc_sec, inc_min} !== 2'b10 || obs !== m_exp) begin
        $display("FAIL count_tick%0d got=%b want=%b", i, obs, m_exp); errs++;
      end
      step();
      checks++;
      if (inc_sec !== 1'b0 || obs !== m_exp) begin
        $display("FAIL count_gap%0d got=%b want=%b", i, obs, m_exp); errs++;
      end
    end
  endtask

  task automatic test_carry();
    seccounter = 59; tick_1hz = 1; step(); tick_1hz = 0;
    checks++;
    if ({inc_sec, inc_min, clr} !== 3'b110 || obs !== m_exp) begin
      $display("FAIL carry got=%b want=%b", obs, m_exp); errs++;
    end
    step();
  endtask

  task automatic test_pause();
    seccounter = 5;
    pueBtn = 1; step(); pueBtn = 0;
    checks++;
    if (running !== 1'b0 || obs !== m_exp) begin
      $display("FAIL pause_enter got=%b want=%b", obs, m_exp); errs++;
    end
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1; step(); tick_1hz = 0;
      checks++;
      if (obs !== 7'b0000000 || obs !== m_exp) begin
        $display("FAIL pause_tick%0d got=%b want=%b", i, obs, 7'b0000000); errs++;
      end
    end
    pueBtn = 1; step(); pueBtn = 0;
    checks++;
    if (running !== 1'b1) begin
      $display("FAIL pause_resume got=%b want=1", running); errs++;
    end
    tick_1hz = 1; step(); tick_1hz = 0;
    checks++;
    if (inc_sec !== 1'b1 || obs !== m_exp) begin
      $display("FAIL resume_count got=%b want=%b", obs, m_exp); errs++;
    end
  endtask

  task automatic test_adjust();
    int n_sec = 0, n_min = 0;
    adj = 1; sel = 1; step();
    checks++;
    if (blink_sec !== 1'b1 || blink_min !== 1'b0 || running !== 1'b1) begin
      $display("FAIL adj_enter got=%b want=0001010", obs); errs++;
    end
    tick_2hz = 1; step(); tick_2hz = 0;
    n_sec += inc_sec; n_min += inc_min;
    step();
    n_sec += inc_sec; n_min += inc_min;
    tick_2hz = 1; step(); tick_2hz = 0;
    n_sec += inc_sec; n_min += inc_min;
    seccounter = 59; tick_1hz = 1; step(); tick_1hz = 0;
    n_sec += inc_sec; n_min += inc_min;
    checks++;
    if (n_sec != 2 || n_min != 0 || blink_sec !== 1'b1) begin
      $display("FAIL adj_sec_pulses got=%0d/%0d want=2/0", n_sec, n_min); errs++;
    end
    sel = 0; tick_2hz = 1; step(); tick_2hz = 0;
    checks++;
    if ({inc_sec, inc_min, blink_min, blink_sec} !== 4'b0110 || obs !== m_exp) begin
      $display("FAIL adj_min got=%b want=%b", obs, m_exp); errs++;
    end
    adj = 0; step();
    checks++;
    if (running !== 1'b1 || blink_min !== 1'b0 || blink_sec !== 1'b0) begin
      $display("FAIL adj_exit got=%b want=0001000", obs); errs++;
    end
    tick_1hz = 1; step(); tick_1hz = 0;
    checks++;
    if ({inc_sec, inc_min} !== 2'b11 || obs !== m_exp) begin
      $display("FAIL adj_restored_run got=%b want=%b", obs, m_exp); errs++;
    end
  endtask

  task automatic test_rstbtn_in_pause();
    seccounter = 5;
    pueBtn = 1; step(); pueBtn = 0;
    rstBtn = 1; tick_1hz = 1; step(); tick_1hz = 0; rstBtn = 0;
    checks++;
    if ({inc_sec, inc_min, clr, running} !== 4'b0011 || obs !== m_exp) begin
      $display("FAIL rstbtn_pause got=%b want=%b", obs, m_exp); errs++;
    end
    tick_1hz = 1; step(); tick_1hz = 0;
    checks++;
    if ({inc_sec, clr} !== 2'b10 || obs !== m_exp) begin
      $display("FAIL rstbtn_then_tick got=%b want=%b", obs, m_exp); errs++;
    end
  endtask

  task automatic test_lap();
    lap_btn = 1; step(); lap_btn = 0;
    checks++;
    if (hold !== LAP || obs !== m_exp) begin
      $display("FAIL lap_press got=%b want=%b", hold, LAP); errs++;
    end
    tick_1hz = 1; step(); tick_1hz = 0;
    checks++;
    if (inc_sec !== 1'b1 || hold !== LAP) begin
      $display("FAIL lap_counting got=%b want=%b", obs, m_exp); errs++;
    end
    rstBtn = 1; step(); rstBtn = 0;
    checks++;
    if (hold !== 1'b0 || clr !== 1'b1) begin
      $display("FAIL lap_clear got=%b want=%b", obs, m_exp); errs++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      tick_1hz   = ($urandom_range(0, 2) == 0);
      tick_2hz   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) rstBtn  = !rstBtn;
      if ($urandom_range(0, 5) == 0) pueBtn  = !pueBtn;
      if ($urandom_range(0, 5) == 0) lap_btn = !lap_btn;
      if ($urandom_range(0, 9) == 0) sel     = !sel;
      if ($urandom_range(0, 19) == 0) adj    = !adj;
      seccounter = $urandom_range(0, 1) ? 6'd59 : 6'($urandom_range(0, 63));
      mincounter = 6'($urandom_range(0, 63));
      step();
      checks++;
      if (obs !== m_exp) begin
        $display("FAIL random_cycle%0d got=%b want=%b", i, obs, m_exp); errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_carry();
    test_pause();
    test_adjust();
    test_rstbtn_in_pause();
    test_lap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
